// File: rtl/mnist_layer_seq.sv
// Sequencer for one fully-connected MNIST layer: pixel handshake, weight-memory addressing and MAC strobes.
// Define MNIST_LAYER_SEQ_PERF_EN to build the stall_cycles performance counter.
module mnist_layer_seq #(
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              weight_rden,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_pix,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              done,
    output logic [15:0]       stall_cycles
);

    localparam int unsigned        DRAIN_W    = 3;
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_INPUTS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, pix_ready_q, mac_clr_q, res_valid_q, done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DRAIN_W-1:0]  drain_q;
    logic [MEM_LAT-1:0]  vld_q;
    logic [DATA_W-1:0]   dat_q [MEM_LAT];
    logic                xfer_c;
    logic                last_c;

    // addr_q doubles as the transfer count; it parks on the last address once reached
    assign xfer_c = pix_valid & pix_ready_q;
    assign last_c = xfer_c && (addr_q == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_STREAM;
            S_STREAM: if (last_c) state_d = S_DRAIN;
            S_DRAIN:  if (drain_q == DRAIN_LAST) state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            pix_ready_q <= 1'b0;
            mac_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            drain_q     <= '0;
            vld_q       <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            pix_ready_q <= (state_d == S_STREAM);
            mac_clr_q   <= (state_d == S_CLEAR);
            res_valid_q <= (state_d == S_RESULT);
            done_q      <= (state_q == S_RESULT) && (state_d == S_IDLE);

            if (state_q == S_CLEAR) begin
                addr_q <= '0;
            end else if (xfer_c && (addr_q != LAST_ADDR)) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (state_q == S_DRAIN) begin
                drain_q <= drain_q + DRAIN_W'(1);
            end else begin
                drain_q <= '0;
            end

            // Delay pipe aligns the pixel with the weight word arriving MEM_LAT cycles later
            vld_q[0] <= xfer_c;
            dat_q[0] <= xfer_c ? pix_data : '0;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign busy        = busy_q;
    assign pix_ready   = pix_ready_q;
    assign weight_addr = addr_q;
    assign weight_rden = xfer_c;
    assign mac_clr     = mac_clr_q;
    assign mac_en      = vld_q[MEM_LAT-1];
    assign mac_pix     = dat_q[MEM_LAT-1];
    assign res_valid   = res_valid_q;
    assign done        = done_q;

`ifdef MNIST_LAYER_SEQ_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of streaming cycles without an offered pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == S_CLEAR) begin
            stall_q <= '0;
        end else if ((state_q == S_STREAM) && !pix_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mnist_layer_seq.sv
// Self-checking bench for mnist_layer_seq: a short 4-input/latency-1 instance and a full 784-input/latency-3 instance.
`timescale 1ns/1ps
module tb_mnist_layer_seq;
    localparam int unsigned A_N = 4;
    localparam int unsigned A_ML = 1;
    localparam int unsigned B_N = 784;
    localparam int unsigned B_ML = 3;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic          a_start = 0, a_valid = 0, a_res_ready = 0;
    logic [DW-1:0] a_data = '0;
    logic          a_busy, a_pix_ready, a_rden, a_clr, a_mac_en, a_rv, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_mac_pix;
    logic [15:0]   a_stall;

    logic          b_start = 0, b_valid = 0, b_res_ready = 0;
    logic [DW-1:0] b_data = '0;
    logic          b_busy, b_pix_ready, b_rden, b_clr, b_mac_en, b_rv, b_done;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_mac_pix;
    logic [15:0]   b_stall;

    mnist_layer_seq #(.N_INPUTS(A_N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(A_ML)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy),
        .pix_valid(a_valid), .pix_data(a_data), .pix_ready(a_pix_ready),
        .weight_addr(a_addr), .weight_rden(a_rden), .mac_clr(a_clr),
        .mac_en(a_mac_en), .mac_pix(a_mac_pix), .res_valid(a_rv),
        .res_ready(a_res_ready), .done(a_done), .stall_cycles(a_stall)
    );

    mnist_layer_seq #(.N_INPUTS(B_N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(B_ML)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
        .pix_valid(b_valid), .pix_data(b_data), .pix_ready(b_pix_ready),
        .weight_addr(b_addr), .weight_rden(b_rden), .mac_clr(b_clr),
        .mac_en(b_mac_en), .mac_pix(b_mac_pix), .res_valid(b_rv),
        .res_ready(b_res_ready), .done(b_done), .stall_cycles(b_stall)
    );

    // Event logs captured mid-cycle
    int            m_rden_cyc[$], m_rden_addr[$], m_mac_cyc[$], m_clr_cyc[$], m_rv_cyc[$], m_done_cyc[$];
    logic [DW-1:0] m_mac_pix[$];
    int            m_bad = 0;
    int            n_rden_cyc[$], n_rden_addr[$], n_mac_cyc[$], n_rv_cyc[$], n_done_cyc[$];
    logic [DW-1:0] n_mac_pix[$];

    always @(negedge clk) begin
        if (a_rden) begin m_rden_cyc.push_back(cyc); m_rden_addr.push_back(int'(a_addr)); end
        if (a_clr) m_clr_cyc.push_back(cyc);
        if (a_mac_en) begin m_mac_cyc.push_back(cyc); m_mac_pix.push_back(a_mac_pix); end
        else if (a_mac_pix !== '0) m_bad++;
        if (a_rv) m_rv_cyc.push_back(cyc);
        if (a_done) m_done_cyc.push_back(cyc);
        if (int'(a_addr) > int'(A_N) - 1) m_bad++;
        if (b_rden) begin n_rden_cyc.push_back(cyc); n_rden_addr.push_back(int'(b_addr)); end
        if (b_mac_en) begin n_mac_cyc.push_back(cyc); n_mac_pix.push_back(b_mac_pix); end
        if (b_rv) n_rv_cyc.push_back(cyc);
        if (b_done) n_done_cyc.push_back(cyc);
    end

    int            exp_s, exp_res_first, exp_acc, exp_stalls;
    int            exp_xfer_cyc[$];
    logic [DW-1:0] exp_xfer_data[$];
    logic [DW-1:0] drv_a [int];
    logic [DW-1:0] drv_b [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        m_rden_cyc.delete(); m_rden_addr.delete(); m_mac_cyc.delete(); m_mac_pix.delete();
        m_clr_cyc.delete(); m_rv_cyc.delete(); m_done_cyc.delete();
        exp_xfer_cyc.delete(); exp_xfer_data.delete();
    endtask

    // One inference on instance A; expected timeline follows from IDLE->CLEAR->STREAM and the pipe latency
    task automatic drive_a(input logic [31:0] low_mask, input int gap_pct, input int hold,
                           input bit sir, input bit fixed_data);
        int k = 0;
        int last = -1;
        int rel;
        bit v;
        clear_a();
        exp_s = cyc;
        exp_stalls = 0;
        exp_res_first = 0;
        exp_acc = 0;
        forever begin
            rel = cyc - exp_s;
            if (rel > 2000) begin
                n_checks++; n_errors++;
                $display("FAIL drive_a_timeout: got cycle %0d, required done before %0d", rel, 2000);
                break;
            end
            if (rel < 2 || k >= int'(A_N)) v = 1'($urandom_range(1));
            else v = !(rel < 32 && low_mask[rel]) && (int'($urandom_range(99)) >= gap_pct);
            a_valid = v;
            a_data = (fixed_data && rel >= 2 && k < int'(A_N)) ? DW'(k + 1) : DW'($urandom);
            if (rel >= 2 && k < int'(A_N)) begin
                if (v) begin
                    exp_xfer_cyc.push_back(cyc);
                    exp_xfer_data.push_back(a_data);
                    k++;
                    if (k == int'(A_N)) begin
                        last = cyc;
                        exp_res_first = last + int'(A_ML) + 1;
                        exp_acc = exp_res_first + hold;
                    end
                end else begin
                    exp_stalls++;
                end
            end
            if (last < 0 || cyc < exp_res_first) begin
                a_res_ready = 1'($urandom_range(1));
                a_start = (rel == 0) ? 1'b1 : 1'($urandom_range(1));
            end else begin
                a_res_ready = (cyc >= exp_acc);
                a_start = sir;
            end
            tick();
            if (last >= 0 && cyc == exp_acc + 1) break;
        end
        a_start = 0; a_valid = 0; a_res_ready = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_pix_ready, a_rden, a_clr, a_mac_en, a_rv, a_done} !== 7'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b required %b", {a_busy, a_pix_ready, a_rden, a_clr, a_mac_en, a_rv, a_done}, 7'b0);
        end
        n_checks++;
        if ({a_addr, a_mac_pix, a_stall} !== '0) begin
            n_errors++; $display("FAIL reset_data: got addr %0d pix %0h stall %0d required 0", a_addr, a_mac_pix, a_stall);
        end
        n_checks++;
        if ({b_busy, b_pix_ready, b_rden, b_clr, b_mac_en, b_rv, b_done, b_addr, b_mac_pix, b_stall} !== '0) begin
            n_errors++; $display("FAIL reset_b: got busy %b addr %0d mac_en %b required 0", b_busy, b_addr, b_mac_en);
        end
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_stream();
        int sc_mask[5] = '{0, 'h18, 0, 0, 0};
        int sc_gap[5]  = '{0, 0, 30, 50, 25};
        int sc_hold[5] = '{0, 0, 5, 2, 0};
        int sc_sir[5]  = '{0, 0, 1, 0, 1};
        int sc_fix[5]  = '{1, 1, 0, 0, 0};
        int got, bad, exp_stall;
        for (int i = 0; i < 5; i++) begin
            drive_a(32'(sc_mask[i]), sc_gap[i], sc_hold[i], sc_sir[i] != 0, sc_fix[i] != 0);
            n_checks++;
            if (m_clr_cyc.size() !== 1) begin n_errors++; $display("FAIL sc%0d clr_count: got %0d required 1", i, m_clr_cyc.size()); end
            got = (m_clr_cyc.size() > 0) ? m_clr_cyc[0] : -1;
            n_checks++;
            if (got !== exp_s + 1) begin n_errors++; $display("FAIL sc%0d clr_cycle: got %0d required %0d", i, got, exp_s + 1); end
            n_checks++;
            if (m_rden_cyc.size() !== int'(A_N)) begin n_errors++; $display("FAIL sc%0d xfer_count: got %0d required %0d", i, m_rden_cyc.size(), A_N); end
            bad = 0;
            for (int k = 0; k < m_rden_cyc.size() && k < exp_xfer_cyc.size(); k++)
                if (m_rden_cyc[k] != exp_xfer_cyc[k] || m_rden_addr[k] != k) bad++;
            n_checks++;
            if (bad !== 0) begin n_errors++; $display("FAIL sc%0d xfer_seq: got %0d wrong cycle/addr entries required 0", i, bad); end
            n_checks++;
            if (m_mac_cyc.size() !== int'(A_N)) begin n_errors++; $display("FAIL sc%0d mac_count: got %0d required %0d", i, m_mac_cyc.size(), A_N); end
            bad = 0;
            for (int k = 0; k < m_mac_cyc.size() && k < exp_xfer_cyc.size(); k++)
                if (m_mac_cyc[k] != exp_xfer_cyc[k] + int'(A_ML) || m_mac_pix[k] !== exp_xfer_data[k]) bad++;
            n_checks++;
            if (bad !== 0) begin n_errors++; $display("FAIL sc%0d mac_seq: got %0d wrong cycle/pixel entries required 0", i, bad); end
            n_checks++;
            if (m_rv_cyc.size() !== sc_hold[i] + 1) begin n_errors++; $display("FAIL sc%0d res_valid_len: got %0d required %0d", i, m_rv_cyc.size(), sc_hold[i] + 1); end
            got = (m_rv_cyc.size() > 0) ? m_rv_cyc[0] : -1;
            n_checks++;
            if (got !== exp_res_first) begin n_errors++; $display("FAIL sc%0d res_valid_cycle: got %0d required %0d", i, got, exp_res_first); end
            got = (m_done_cyc.size() == 1) ? m_done_cyc[0] : -1;
            n_checks++;
            if (got !== exp_acc + 1) begin n_errors++; $display("FAIL sc%0d done_cycle: got %0d (count %0d) required %0d", i, got, m_done_cyc.size(), exp_acc + 1); end
`ifdef MNIST_LAYER_SEQ_PERF_EN
            exp_stall = exp_stalls;
`else
            exp_stall = 0;
`endif
            n_checks++;
            if (int'(a_stall) !== exp_stall) begin n_errors++; $display("FAIL sc%0d stall_cycles: got %0d required %0d", i, a_stall, exp_stall); end
            n_checks++;
            if (a_busy !== 1'b0) begin n_errors++; $display("FAIL sc%0d busy_after: got %b required 0", i, a_busy); end
        end
        n_checks++;
        if (m_bad !== 0) begin n_errors++; $display("FAIL output_rules: got %0d violations required 0", m_bad); end
    endtask

    task automatic test_reset_abort();
        int s, late;
        clear_a();
        s = cyc;
        a_start = 1; a_valid = 1; a_res_ready = 0; a_data = DW'($urandom);
        tick();
        a_start = 0;
        repeat (3) begin a_data = DW'($urandom); tick(); end
        a_valid = 0; reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_pix_ready, a_rden, a_clr, a_mac_en, a_rv, a_done} !== 7'b0) begin
            n_errors++; $display("FAIL abort_ctrl: got %b required %b", {a_busy, a_pix_ready, a_rden, a_clr, a_mac_en, a_rv, a_done}, 7'b0);
        end
        n_checks++;
        if ({a_addr, a_mac_pix, a_stall} !== '0) begin
            n_errors++; $display("FAIL abort_data: got addr %0d pix %0h stall %0d required 0", a_addr, a_mac_pix, a_stall);
        end
        repeat (4) tick();
        late = 0;
        foreach (m_mac_cyc[k]) if (m_mac_cyc[k] >= s + 5) late++;
        n_checks++;
        if (late !== 0) begin n_errors++; $display("FAIL abort_mac_after_reset: got %0d pulses required 0", late); end
        n_checks++;
        if (m_rden_cyc.size() !== 2) begin n_errors++; $display("FAIL abort_xfers: got %0d required 2", m_rden_cyc.size()); end
        drive_a(32'h0, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if (m_clr_cyc.size() !== 1) begin n_errors++; $display("FAIL rerun_clr: got %0d required 1", m_clr_cyc.size()); end
        n_checks++;
        if (m_rden_addr.size() !== int'(A_N) || m_rden_addr[0] !== 0) begin
            n_errors++; $display("FAIL rerun_addr: got count %0d required %0d from addr 0", m_rden_addr.size(), A_N);
        end
        n_checks++;
        if (m_mac_cyc.size() !== int'(A_N)) begin n_errors++; $display("FAIL rerun_mac: got %0d required %0d", m_mac_cyc.size(), A_N); end
    endtask

    task automatic test_back_to_back();
        localparam int P = int'(A_N) + int'(A_ML) + 3;
        int s, x, bad;
        clear_a();
        s = cyc;
        for (int r = 0; r < 3 * P; r++) begin
            a_start = 1; a_valid = 1; a_res_ready = 1;
            a_data = DW'($urandom);
            drv_a[cyc] = a_data;
            tick();
        end
        a_start = 0; a_valid = 0; a_res_ready = 0;
        repeat (3) tick();
        n_checks++;
        if (m_clr_cyc.size() !== 3) begin n_errors++; $display("FAIL b2b_clr_count: got %0d required 3", m_clr_cyc.size()); end
        n_checks++;
        if (m_rden_cyc.size() !== 3 * int'(A_N)) begin n_errors++; $display("FAIL b2b_xfer_count: got %0d required %0d", m_rden_cyc.size(), 3 * A_N); end
        n_checks++;
        if (m_done_cyc.size() !== 3) begin n_errors++; $display("FAIL b2b_done_count: got %0d required 3", m_done_cyc.size()); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (i < m_clr_cyc.size() && m_clr_cyc[i] != s + 1 + i * P) bad++;
            if (i < m_done_cyc.size() && m_done_cyc[i] != s + (i + 1) * P) bad++;
            for (int j = 0; j < int'(A_N); j++) begin
                int n = i * int'(A_N) + j;
                x = s + 2 + i * P + j;
                if (n < m_rden_cyc.size() && (m_rden_cyc[n] != x || m_rden_addr[n] != j)) bad++;
                if (n >= m_mac_cyc.size() || m_mac_cyc[n] != x + int'(A_ML) || m_mac_pix[n] !== drv_a[x]) bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL b2b_timeline: got %0d wrong events required 0", bad); end
    endtask

    task automatic test_long_latency();
        int s, bad, last_x;
        int got;
        s = cyc;
        for (int r = 0; r < int'(B_N) + 20; r++) begin
            b_start = (r == 0); b_valid = 1; b_res_ready = 1;
            b_data = DW'($urandom);
            drv_b[cyc] = b_data;
            tick();
            if (n_done_cyc.size() > 0) break;
        end
        b_start = 0; b_valid = 0; b_res_ready = 0;
        repeat (2) tick();
        n_checks++;
        if (n_done_cyc.size() !== 1) begin n_errors++; $display("FAIL long_done: got %0d pulses required 1", n_done_cyc.size()); end
        n_checks++;
        if (n_rden_cyc.size() !== int'(B_N)) begin n_errors++; $display("FAIL long_xfer_count: got %0d required %0d", n_rden_cyc.size(), B_N); end
        n_checks++;
        if (n_mac_cyc.size() !== int'(B_N)) begin n_errors++; $display("FAIL long_mac_count: got %0d required %0d", n_mac_cyc.size(), B_N); end
        bad = 0;
        for (int j = 0; j < int'(B_N); j++) begin
            int x = s + 2 + j;
            if (j >= n_rden_cyc.size() || n_rden_cyc[j] != x || n_rden_addr[j] != j) bad++;
            if (j >= n_mac_cyc.size() || n_mac_cyc[j] != x + int'(B_ML) || n_mac_pix[j] !== drv_b[x]) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL long_seq: got %0d wrong events required 0", bad); end
        last_x = s + 2 + int'(B_N) - 1;
        got = (n_mac_cyc.size() > 0) ? n_mac_cyc[n_mac_cyc.size() - 1] : -1;
        n_checks++;
        if (got !== last_x + int'(B_ML)) begin n_errors++; $display("FAIL long_last_mac: got %0d required %0d", got, last_x + int'(B_ML)); end
        got = (n_rv_cyc.size() > 0) ? n_rv_cyc[0] : -1;
        n_checks++;
        if (got !== last_x + int'(B_ML) + 1) begin n_errors++; $display("FAIL long_drain_len: got res_valid at %0d required %0d", got, last_x + int'(B_ML) + 1); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_reset_abort();
        test_back_to_back();
        test_long_latency();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mnist_layer_seq.md
Name: mnist_layer_seq

Overview:
Sequencer for one fully-connected MNIST layer. It accepts a pixel stream through a valid/ready handshake and drives the address and read enable of the shared weight memories. It delays pixel data to line up with weight-memory read latency and issues clear and enable strobes to the per-neuron MAC units. After the last input it holds a result-valid until downstream accepts it.

Parameters:
N_INPUTS, 784, inputs per inference (weight words per neuron memory)
ADDR_W, 10, weight address width; must satisfy 2**ADDR_W >= N_INPUTS
DATA_W, 16, pixel width (signed)
MEM_LAT, 1, weight memory read latency in clk cycles (1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin inference; sampled only in IDLE
busy  out  1  high in any state except IDLE
pix_valid  in  1  pixel available
pix_data  in  DATA_W  signed pixel
pix_ready  out  1  sequencer accepts pixel
weight_addr  out  ADDR_W  address to all neuron weight memories
weight_rden  out  1  read enable to weight memories
mac_clr  out  1  clear all neuron accumulators
mac_en  out  1  accumulate mac_pix * weight this cycle
mac_pix  out  DATA_W  pixel delayed MEM_LAT cycles, aligned with weight q
res_valid  out  1  accumulators hold final sums
res_ready  in  1  downstream consumes sums
done  out  1  one-cycle pulse after result accepted
stall_cycles  out  16  STREAM cycles with no pixel (see Optional Feature)

Behaviour:
- Reset: state=IDLE, count=0, delay pipe flushed. All outputs 0: busy, pix_ready, weight_addr, weight_rden, mac_clr, mac_en, mac_pix, res_valid, done, stall_cycles. Reset mid-operation aborts immediately; no mac_en after reset.
- FSM states:
  - IDLE: start=1 -> CLEAR. All other inputs ignored.
  - CLEAR: one cycle, mac_clr=1, count<=0 -> STREAM.
  - STREAM: pix_ready=1. A transfer is pix_valid & pix_ready. On a transfer: weight_rden=1 (combinational), weight_addr=count (registered), count<=count+1, and pix_data plus a valid bit enter a MEM_LAT-deep shift pipe. A transfer with count==N_INPUTS-1 -> DRAIN.
  - DRAIN: pix_ready=0; wait until the pipe is empty (exactly MEM_LAT cycles after the last transfer) -> RESULT.
  - RESULT: res_valid=1 and held until res_ready=1 -> IDLE. done=1 on the first IDLE cycle.
- mac_en and mac_pix come from the pipe output, exactly MEM_LAT cycles after the corresponding transfer. mac_en can be high in the first DRAIN cycles. mac_pix=0 when mac_en=0.
- weight_addr holds its last value when there is no transfer; it never exceeds N_INPUTS-1. weight_rden=0 outside STREAM.
- Exactly N_INPUTS mac_en pulses per inference. mac_clr precedes the first pulse by at least one cycle.
- Simultaneous events:
  - start during busy: ignored.
  - res_ready outside RESULT: ignored.
  - start together with res_ready in RESULT: start ignored; start must be re-asserted in IDLE.
- Gaps in pix_valid stall the sequence with no loss or duplication.

Optional Feature:
MNIST_LAYER_SEQ_PERF_EN.
- Defined: stall_cycles is a saturating 16-bit counter of STREAM cycles with pix_valid=0. It clears in CLEAR and holds its value through DRAIN, RESULT and IDLE.
- Undefined: stall_cycles is tied to 0 and no counter logic exists.

Test Plan:
1. N_INPUTS=4, MEM_LAT=1; start at cycle 0, pix_valid held high with data 1,2,3,4, res_ready=1 -> mac_clr at cycle 1; transfers at cycles 2-5 with weight_addr 0,1,2,3; mac_en at cycles 3-6 with mac_pix 1,2,3,4; res_valid at cycle 7; done at cycle 8.
2. Same setup, pix_valid low at cycles 3-4 -> exactly 4 transfers, addresses 0..3 with none repeated; mac_en pulses=4; with the macro defined, stall_cycles=2.
3. res_ready low for 5 cycles in RESULT -> res_valid held 6 cycles; done occurs only after acceptance; start asserted during RESULT is ignored.
4. reset asserted after the 2nd transfer -> next cycle all outputs 0, busy=0. A fresh start re-runs from weight_addr 0 with mac_clr.
5. MEM_LAT=3, N_INPUTS=784, continuous valid -> last mac_en 3 cycles after the transfer at weight_addr 783; DRAIN lasts 3 cycles; 784 mac_en pulses total.
6. start held high continuously -> back-to-back inferences, each preceded by mac_clr. No stray transfer occurs in IDLE.
